// File: rtl/rv_ctrl_pkg.sv
// Shared decode-stage definitions: opcode constants, ALU/immediate selector encodings
// and the control bundle carried in the ID/EX register.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [5:0] ALU_SEL_MEM   = 6'b000000;
    localparam logic [5:0] ALU_SEL_LUI   = 6'b110000;
    localparam logic [5:0] ALU_SEL_AUIPC = 6'b110001;
    localparam logic [5:0] ALU_SEL_JUMP  = 6'b110010;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [5:0] alu_sel;
        imm_sel_e   imm_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       pc_sel;
        logic       jtype;
        logic       reg_write;
        logic       illegal;
    } ctrl_bundle_t;

    // Base-ISA ALU selector; alt is the funct7[5] bit, only meaningful for SUB/SRA/SRAI.
    function automatic logic [5:0] alu_sel_base(input logic alt, input logic [2:0] f3);
        return {2'b00, alt, f3};
    endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Pure combinational RV32IM decoder: instruction word to control bundle, plus the
// register-usage and multi-cycle flags the pipeline register needs.
import rv_ctrl_pkg::*;

module rv_ctrl_decode #(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         rs1_used,
    output logic         rs2_used,
    output logic         is_mul,
    output logic         is_div
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        ctrl          = '0;
        ctrl.rs1      = instr[19:15];
        ctrl.rs2      = instr[24:20];
        ctrl.rd       = instr[11:7];
        ctrl.mem_size = f3;
        legal         = 1'b1;
        is_mul        = 1'b0;
        is_div        = 1'b0;
        rs1_used      = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        rs2_used      = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);

        case (opcode)
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    ctrl.alu_sel = alu_sel_base(1'b0, f3);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    ctrl.alu_sel = alu_sel_base(1'b1, f3);
                end else if (f7 == F7_MULDIV && ENABLE_M != 0) begin
                    ctrl.alu_sel = {3'b010, f3};
                    is_mul       = !f3[2];
                    is_div       = f3[2];
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_I;
                ctrl.alu_sel   = alu_sel_base(1'b0, f3);
                // Shift-immediates reuse funct7; only SRAI may set the alt bit.
                if (f3 == 3'b001) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) begin
                        ctrl.alu_sel = alu_sel_base(1'b1, f3);
                    end else if (f7 != F7_BASE) begin
                        legal = 1'b0;
                    end
                end
            end
            OPC_LOAD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_I;
                ctrl.alu_sel   = ALU_SEL_MEM;
                legal          = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.imm_sel   = IMM_S;
                ctrl.alu_sel   = ALU_SEL_MEM;
                legal          = !f3[2] && (f3 != 3'b011);
            end
            OPC_BRANCH: begin
                ctrl.pc_sel  = 1'b1;
                ctrl.imm_sel = IMM_B;
                ctrl.alu_sel = {3'b100, f3};
                legal        = (f3[2:1] != 2'b01);
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.alu_sel   = ALU_SEL_LUI;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.alu_sel   = ALU_SEL_AUIPC;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_sel    = 1'b1;
                ctrl.jtype     = 1'b1;
                ctrl.imm_sel   = IMM_J;
                ctrl.alu_sel   = ALU_SEL_JUMP;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_sel    = 1'b1;
                ctrl.jtype     = 1'b1;
                ctrl.imm_sel   = IMM_I;
                ctrl.alu_sel   = ALU_SEL_JUMP;
                legal          = (f3 == 3'b000);
            end
            OPC_FENCE: begin
                legal = 1'b1;
            end
            OPC_SYSTEM: begin
                legal = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // An illegal instruction must not cause any architectural side effect downstream.
        if (!legal) begin
            ctrl.alu_sel   = '0;
            ctrl.imm_sel   = IMM_NONE;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.pc_sel    = 1'b0;
            ctrl.jtype     = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.illegal   = 1'b1;
            is_mul         = 1'b0;
            is_div         = 1'b0;
        end
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Registered decode stage: ID/EX control register with load-use bubbles, flush and
// issue stalling while a multi-cycle MUL/DIV occupies the execute stage.
import rv_ctrl_pkg::*;

module id_ctrl_pipe #(
    parameter int ADDR_W   = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8,
    parameter int ENABLE_M = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [5:0]        out_alu_sel,
    output logic [2:0]        out_imm_sel,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [2:0]        out_mem_size,
    output logic              out_pc_sel,
    output logic              out_jtype,
    output logic              out_reg_write,
    output logic              out_illegal,
    output logic              mdu_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    ctrl_bundle_t      dec_ctrl;
    logic              dec_rs1_used;
    logic              dec_rs2_used;
    logic              dec_is_mul;
    logic              dec_is_div;

    ctrl_bundle_t      ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;

    logic              hazard;
    logic              ready;
    logic              accept;

    rv_ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .is_mul   (dec_is_mul),
        .is_div   (dec_is_div)
    );

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // valid never depends on ready, and a held entry stays stable until consumed.
    always_comb begin
        hazard = ex_mem_read && (ex_rd != 5'd0) &&
                 ((dec_rs1_used && dec_ctrl.rs1 == ex_rd) ||
                  (dec_rs2_used && dec_ctrl.rs2 == ex_rd));
        ready  = !flush && !hazard && (mdu_cnt_q == '0) && (!valid_q || out_ready);
        accept = in_valid && ready;

        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        mdu_cnt_d = (mdu_cnt_q == '0) ? '0 : mdu_cnt_q - 1'b1;

        if (flush) begin
            valid_d   = 1'b0;
            mdu_cnt_d = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            pc_d    = in_pc;
            if (dec_is_mul) begin
                mdu_cnt_d = MUL_LOAD;
            end else if (dec_is_div) begin
                mdu_cnt_d = DIV_LOAD;
            end
        end else if (out_ready) begin
            // Entry consumed with nothing taken (idle, hazard or MDU stall): bubble.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q    <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            mdu_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign in_ready      = ready;
    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_rs1       = ctrl_q.rs1;
    assign out_rs2       = ctrl_q.rs2;
    assign out_rd        = ctrl_q.rd;
    assign out_alu_sel   = ctrl_q.alu_sel;
    assign out_imm_sel   = ctrl_q.imm_sel;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_mem_size  = ctrl_q.mem_size;
    assign out_pc_sel    = ctrl_q.pc_sel;
    assign out_jtype     = ctrl_q.jtype;
    assign out_reg_write = ctrl_q.reg_write;
    assign out_illegal   = ctrl_q.illegal;
    assign mdu_busy      = (mdu_cnt_q != '0);

endmodule
